shared_mul_rr_scheduler: RTL
============================

Name: shared_mul_rr_scheduler

Overview:
Shares one pipelined signed/unsigned n-bit multiplier among N_REQ requesters. A round-robin arbiter accepts at most one operation per cycle through a valid/ready handshake. Each accepted operation is issued into a fixed-latency pipeline, and its 2n-bit product returns on one result bus tagged with the requester index. The block sits between several arithmetic clients and a single multiplier resource, so the design instantiates one multiplier instead of N_REQ.

Parameters:
n, 8, operand width in bits; the product is 2n bits
N_REQ, 4, number of requesters; must be at least 2
LATENCY, 2, registered stages from acceptance to result; must be at least 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_vld  input  N_REQ  per-requester request valid
req_rdy  output  N_REQ  per-requester grant; one-hot or zero
req_a  input  N_REQ*n  packed operand A; requester i uses bits [i*n +: n]
req_b  input  N_REQ*n  packed operand B, same packing as req_a
req_signed  input  N_REQ  per-requester mode: 1 = two's-complement multiply, 0 = unsigned
res_vld  output  1  result valid, asserted for exactly one cycle per accepted operation
res_id  output  $clog2(N_REQ)  index of the requester that owns the result
res  output  2n  product

Behaviour:
- Handshake: an operation from requester i is accepted on a rising edge where req_vld[i] and req_rdy[i] are both 1.
- req_rdy is combinational from req_vld and the priority pointer ptr.
  - req_rdy[i] = 1 only for the first requester with req_vld set, scanning ptr, ptr+1, … modulo N_REQ.
  - If no requester is valid, req_rdy is all zero.
- Results have no backpressure, so the scheduler is always able to accept one operation per cycle.
- Requester-side rules:
  - A requester holds a, b and signed stable while vld=1 and rdy=0.
  - A requester may drop vld without being granted.
- ptr update, on each cycle with an acceptance from requester g: ptr <= (g+1) mod N_REQ.
  - With no acceptance, ptr holds.
  - ptr wrap-around: from N_REQ-1 it goes to 0.
- Pipeline capture: on acceptance, stage 1 captures valid=1, id=g, a, b and signed. Otherwise stage 1 captures valid=0; the data fields are don't-care.
- Pipeline stages: stages 2..LATENCY shift valid, id and the partial or complete product every cycle. The pipeline never stalls.
- Timing: an operation accepted at edge t gives res_vld=1 in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput: one result per cycle with back-to-back acceptances.
- Arithmetic:
  - signed=1: both operands are sign-extended to 2n bits, and res is the 2n-bit two's-complement product.
  - signed=0: operands are zero-extended to 2n bits.
  - The product is computed no later than the final stage.
  - Boundaries that must be exact:
    - smin*smin = +2^(2n-2)
    - smin*(-1) = +2^(n-1)
    - umax*umax = 2^(2n) - 2^(n+1) + 1
- Mode is per operation: different requesters may use different modes in consecutive cycles, and each result uses the mode captured at its acceptance.
- Reset values:
  - All pipeline valid bits 0; ptr = 0.
  - res_vld = 0, res_id = 0, res = 0.
  - req_rdy follows its combinational rule from ptr = 0.
- Reset mid-operation: operations in flight are discarded, and no res_vld is produced for them after reset.
  - An operation whose handshake coincides with the rst=1 edge is not accepted.
- Simultaneous events: any number of requesters asserting valid in the same cycle produces exactly one grant.
  - A requester granted this cycle may request again next cycle; it waits behind the other valid requesters per ptr.
- Starvation bound: a requester holding vld is granted within N_REQ cycles.

Optional Feature:
Macro: SHARED_MUL_RR_SCHEDULER_STATS_EN.
- Defined:
  - Extra output port op_cnt, N_REQ*16 bits packed, one 16-bit counter per requester.
  - Each counter increments on acceptance from its requester and saturates at 16'hFFFF.
  - All counters clear to 0 on rst.
- Not defined:
  - The op_cnt port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
Default parameters unless stated: n=4, N_REQ=4, LATENCY=2.
- Single requester 0, signed=1, a=4'hD (-3), b=4'h5 → req_rdy=4'b0001; after 2 cycles res_vld=1, res_id=0, res=8'hF1 (-15).
- Single requester 2, signed=0, a=4'hD, b=4'h5 → res_id=2, res=8'h41 (65).
- Signed corners: 4'h8*4'h8 → 8'h40; 4'h8*4'hF → 8'h08. Unsigned corner: 4'hF*4'hF → 8'hE1. All issued back-to-back → three consecutive res_vld cycles in issue order.
- All four requesters valid continuously from reset → grant order 0,1,2,3,0,1; res_id follows the same order 2 cycles later. Drop requester 1 mid-run → order continues 2,3,0,2,3,0.
- Accept two operations, assert rst for one cycle before either result emerges → no res_vld after reset. After reset, requesters 3 and 1 valid → first grant to 1 (ptr=0).
- With SHARED_MUL_RR_SCHEDULER_STATS_EN: issue 5 ops from requester 1 and 2 from requester 3 → op_cnt slices {0,5,0,2}. Force 70000 grants to requester 0 → its slice holds 16'hFFFF.

Source files
------------

// File: rtl/shared_mul_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined signed/unsigned multiplier among N_REQ requesters.
// Define SHARED_MUL_RR_SCHEDULER_STATS_EN to add per-requester saturating operation counters (op_cnt).
module shared_mul_rr_scheduler #(
  parameter int n       = 8,
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  output logic [N_REQ-1:0]         req_rdy,
  input  logic [N_REQ*n-1:0]       req_a,
  input  logic [N_REQ*n-1:0]       req_b,
  input  logic [N_REQ-1:0]         req_signed,
  output logic                     res_vld,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [2*n-1:0]           res
`ifdef SHARED_MUL_RR_SCHEDULER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]      op_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int PW   = 2 * n;

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  int              scan_idx;

  // First valid requester scanning ptr, ptr+1, ... modulo N_REQ.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    req_rdy   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(ptr_reg) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!grant_any && req_vld[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[ID_W-1:0];
      end
    end
    req_rdy[grant_idx] = grant_any;
  end

  assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  logic [n-1:0] sel_a;
  logic [n-1:0] sel_b;
  logic         sel_signed;

  assign sel_a      = req_a[grant_idx*n +: n];
  assign sel_b      = req_b[grant_idx*n +: n];
  assign sel_signed = req_signed[grant_idx];

  logic            s1_vld_reg;
  logic [ID_W-1:0] s1_id_reg;
  logic [n-1:0]    s1_a_reg;
  logic [n-1:0]    s1_b_reg;
  logic            s1_signed_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      s1_vld_reg    <= 1'b0;
      s1_id_reg     <= '0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_signed_reg <= 1'b0;
    end else begin
      s1_vld_reg <= grant_any;
      if (grant_any) begin
        ptr_reg       <= ptr_next;
        s1_id_reg     <= grant_idx;
        s1_a_reg      <= sel_a;
        s1_b_reg      <= sel_b;
        s1_signed_reg <= sel_signed;
      end
    end
  end

  // Extending to 2n bits and keeping the low 2n bits of the product covers both modes.
  logic [PW-1:0] ext_a;
  logic [PW-1:0] ext_b;
  logic [PW-1:0] s1_prod;

  assign ext_a   = s1_signed_reg ? {{n{s1_a_reg[n-1]}}, s1_a_reg} : {{n{1'b0}}, s1_a_reg};
  assign ext_b   = s1_signed_reg ? {{n{s1_b_reg[n-1]}}, s1_b_reg} : {{n{1'b0}}, s1_b_reg};
  assign s1_prod = ext_a * ext_b;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign res_vld = s1_vld_reg;
      assign res_id  = s1_id_reg;
      assign res     = s1_prod;
    end else begin : g_pipe
      logic            vld_pipe_reg  [2:LATENCY];
      logic [ID_W-1:0] id_pipe_reg   [2:LATENCY];
      logic [PW-1:0]   prod_pipe_reg [2:LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 2; s <= LATENCY; s++) begin
            vld_pipe_reg[s]  <= 1'b0;
            id_pipe_reg[s]   <= '0;
            prod_pipe_reg[s] <= '0;
          end
        end else begin
          vld_pipe_reg[2]  <= s1_vld_reg;
          id_pipe_reg[2]   <= s1_id_reg;
          prod_pipe_reg[2] <= s1_prod;
          for (int s = 3; s <= LATENCY; s++) begin
            vld_pipe_reg[s]  <= vld_pipe_reg[s-1];
            id_pipe_reg[s]   <= id_pipe_reg[s-1];
            prod_pipe_reg[s] <= prod_pipe_reg[s-1];
          end
        end
      end

      assign res_vld = vld_pipe_reg[LATENCY];
      assign res_id  = id_pipe_reg[LATENCY];
      assign res     = prod_pipe_reg[LATENCY];
    end
  endgenerate

`ifdef SHARED_MUL_RR_SCHEDULER_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [15:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (grant_any && grant_idx == ID_W'(gi) && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign op_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule
